// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register.
// Captures decoded fields and register-file operands for the execute stage,
// folds a same-cycle writeback into the captured operands, detects load-use
// hazards (inserting a bubble), honours stall/flush from hazard control and
// keeps a saturating count of inserted bubbles for debug.
//
// Slot semantics: valid_o marks the execute slot as holding a real
// instruction. Each posedge the slot is either flushed (killed), held
// (stall_i, operands refreshed from writeback), bubbled (load-use, decode
// must hold its instruction while loaduse_o is high) or loaded from decode.
// regwren_o and memread_o are never high unless valid_o is high.
module id_ex_stage_reg #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    input  logic              regwren_i,
    input  logic              memread_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [DWIDTH-1:0] wb_data_i,
    input  logic              wb_regwren_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [DWIDTH-1:0] rs1data_o,
    output logic [DWIDTH-1:0] rs2data_o,
    output logic              regwren_o,
    output logic              memread_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              loaduse_o,
    output logic [15:0]       bubble_cnt_o
);

    logic [DWIDTH-1:0] rs1_byp;
    logic [DWIDTH-1:0] rs2_byp;
    logic              wb_hit_rs1_held;
    logic              wb_hit_rs2_held;
    logic              bubble;
    logic              capture;
    logic [15:0]       bubble_cnt;
    logic [15:0]       bubble_cnt_nxt;

    // A load in execute whose destination feeds the instruction in decode.
    always_comb begin
        loaduse_o = valid_o & memread_o & (rd_o != 5'd0) & valid_i &
                    ((rd_o == rs1_i) | (rd_o == rs2_i));
    end

    // Slot action this cycle: flush beats stall, stall beats the bubble.
    always_comb begin
        bubble  = ~flush_i & ~stall_i & loaduse_o;
        capture = ~flush_i & ~stall_i & ~loaduse_o;
    end

    // Writeback bypass into the decode operands; x0 is never forwarded.
    always_comb begin
        rs1_byp = rs1data_i;
        rs2_byp = rs2data_i;
        if (wb_regwren_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_i)) begin
            rs1_byp = wb_data_i;
        end
        if (wb_regwren_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_i)) begin
            rs2_byp = wb_data_i;
        end
    end

    // Writeback hits on operands already held in the slot (used while stalled).
    always_comb begin
        wb_hit_rs1_held = wb_regwren_i & (wb_rd_i != 5'd0) & (wb_rd_i == rs1_o);
        wb_hit_rs2_held = wb_regwren_i & (wb_rd_i != 5'd0) & (wb_rd_i == rs2_o);
    end

    // Slot occupancy and its gated side-effect flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o   <= 1'b0;
            regwren_o <= 1'b0;
            memread_o <= 1'b0;
        end else if (flush_i || bubble) begin
            valid_o   <= 1'b0;
            regwren_o <= 1'b0;
            memread_o <= 1'b0;
        end else if (capture) begin
            valid_o   <= valid_i;
            regwren_o <= regwren_i & valid_i;
            memread_o <= memread_i & valid_i;
        end
    end

    // Decoded payload; only reloaded on a capture, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o   <= '0;
            imm_o  <= '0;
            rs1_o  <= '0;
            rs2_o  <= '0;
            rd_o   <= '0;
            ctrl_o <= '0;
        end else if (capture) begin
            pc_o   <= pc_i;
            imm_o  <= imm_i;
            rs1_o  <= rs1_i;
            rs2_o  <= rs2_i;
            rd_o   <= rd_i;
            ctrl_o <= ctrl_i;
        end
    end

    // Operands: bypassed on capture, refreshed from writeback while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1data_o <= '0;
            rs2data_o <= '0;
        end else if (capture) begin
            rs1data_o <= rs1_byp;
            rs2data_o <= rs2_byp;
        end else if (!flush_i && stall_i) begin
            if (wb_hit_rs1_held) begin
                rs1data_o <= wb_data_i;
            end
            if (wb_hit_rs2_held) begin
                rs2data_o <= wb_data_i;
            end
        end
    end

    // Next bubble count, sticking at all-ones instead of wrapping.
    always_comb begin
        bubble_cnt_nxt = bubble_cnt;
        if (bubble && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt_nxt = bubble_cnt + 16'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else begin
            bubble_cnt <= bubble_cnt_nxt;
        end
    end

    assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        rst;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] pc_i, imm_i, rs1data_i, rs2data_i, wb_data_i;
  logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
  logic        regwren_i, memread_i, wb_regwren_i;
  logic [7:0]  ctrl_i;
  logic        valid_o, regwren_o, memread_o, loaduse_o;
  logic [31:0] pc_o, imm_o, rs1data_o, rs2data_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [7:0]  ctrl_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int failures = 0;

  // Reference model of the execute slot.
  logic        m_valid, m_regwren, m_memread;
  logic [31:0] m_pc, m_imm, m_rs1data, m_rs2data;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [7:0]  m_ctrl;
  logic [15:0] m_cnt;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1data_i(rs1data_i), .rs2data_i(rs2data_i), .regwren_i(regwren_i),
    .memread_i(memread_i), .ctrl_i(ctrl_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .wb_regwren_i(wb_regwren_i), .valid_o(valid_o), .pc_o(pc_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rs1data_o(rs1data_o),
    .rs2data_o(rs2data_o), .regwren_o(regwren_o), .memread_o(memread_o),
    .ctrl_o(ctrl_o), .loaduse_o(loaduse_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_valid = 0; m_regwren = 0; m_memread = 0;
    m_pc = 0; m_imm = 0; m_rs1data = 0; m_rs2data = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  function automatic logic model_lu();
    return m_valid && m_memread && (m_rd != 0) && valid_i &&
           ((m_rd == rs1_i) || (m_rd == rs2_i));
  endfunction

  function automatic logic wb_hits(input logic [4:0] a);
    return wb_regwren_i && (wb_rd_i != 0) && (wb_rd_i == a);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (flush_i) begin
      m_valid = 0; m_regwren = 0; m_memread = 0;
    end else if (stall_i) begin
      if (wb_hits(m_rs1)) m_rs1data = wb_data_i;
      if (wb_hits(m_rs2)) m_rs2data = wb_data_i;
    end else if (model_lu()) begin
      m_valid = 0; m_regwren = 0; m_memread = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else begin
      m_valid   = valid_i;
      m_regwren = regwren_i && valid_i;
      m_memread = memread_i && valid_i;
      m_pc = pc_i; m_imm = imm_i; m_ctrl = ctrl_i;
      m_rs1 = rs1_i; m_rs2 = rs2_i; m_rd = rd_i;
      m_rs1data = wb_hits(rs1_i) ? wb_data_i : rs1data_i;
      m_rs2data = wb_hits(rs2_i) ? wb_data_i : rs2data_i;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    valid_i = 0; stall_i = 0; flush_i = 0;
    pc_i = 0; imm_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
    rs1data_i = 0; rs2data_i = 0; regwren_i = 0; memread_i = 0; ctrl_i = 0;
    wb_rd_i = 0; wb_data_i = 0; wb_regwren_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0;
    drive_idle();
    model_reset();
    #3;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    checks++; if (bubble_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %h want 0", bubble_cnt_o); end
    checks++; if ({regwren_o, memread_o, loaduse_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {regwren_o, memread_o, loaduse_o}); end
    checks++; if ({pc_o, rs1data_o, rs2data_o} !== 96'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {pc_o, rs1data_o, rs2data_o}); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_capture();
    drive_idle();
    valid_i = 1; pc_i = 32'h100; rs1data_i = 32'h11; rs2data_i = 32'h22; rd_i = 5;
    regwren_i = 1; rs1_i = 1; rs2_i = 2; imm_i = 32'h7; ctrl_i = 8'h5A;
    tick();
    checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL cap_pc: got %h want 100", pc_o); end
    checks++; if ({rs1data_o, rs2data_o} !== {32'h11, 32'h22}) begin failures++; $display("FAIL cap_ops: got %h %h want 11 22", rs1data_o, rs2data_o); end
    checks++; if ({valid_o, regwren_o, memread_o, rd_o} !== {3'b110, 5'd5}) begin failures++; $display("FAIL cap_ctl: got %b %b %b rd=%0d want 1 1 0 rd=5", valid_o, regwren_o, memread_o, rd_o); end
    checks++; if ({imm_o, ctrl_o} !== {32'h7, 8'h5A}) begin failures++; $display("FAIL cap_imm_ctrl: got %h %h want 7 5a", imm_o, ctrl_o); end
  endtask

  task automatic test_bypass();
    drive_idle();
    valid_i = 1; rs1_i = 7; rs1data_i = 32'hAAAA; rs2_i = 8; rs2data_i = 32'h8888;
    wb_regwren_i = 1; wb_rd_i = 7; wb_data_i = 32'h1234;
    tick();
    checks++; if (rs1data_o !== 32'h1234) begin failures++; $display("FAIL byp_hit: got %h want 1234", rs1data_o); end
    checks++; if (rs2data_o !== 32'h8888) begin failures++; $display("FAIL byp_miss: got %h want 8888", rs2data_o); end
    rs1_i = 0; wb_rd_i = 0;
    tick();
    checks++; if (rs1data_o !== 32'hAAAA) begin failures++; $display("FAIL byp_x0: got %h want aaaa", rs1data_o); end
  endtask

  task automatic test_loaduse();
    drive_idle();
    valid_i = 1; memread_i = 1; regwren_i = 1; rd_i = 3; rs1_i = 1; rs2_i = 2; pc_i = 32'h1F0;
    tick();
    drive_idle();
    valid_i = 1; rs1_i = 4; rs2_i = 3; rd_i = 6; pc_i = 32'h200; regwren_i = 1;
    rs2data_i = 32'h3333;
    #1;
    checks++; if (loaduse_o !== 1'b1) begin failures++; $display("FAIL lu_detect: got %0b want 1", loaduse_o); end
    tick();
    checks++; if ({valid_o, regwren_o, memread_o} !== 3'b000) begin failures++; $display("FAIL lu_bubble: got %b want 000", {valid_o, regwren_o, memread_o}); end
    checks++; if (bubble_cnt_o !== 16'd1) begin failures++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt_o); end
    // Load result is written back while the held instruction is recaptured.
    wb_regwren_i = 1; wb_rd_i = 3; wb_data_i = 32'hCAFE;
    #1;
    checks++; if (loaduse_o !== 1'b0) begin failures++; $display("FAIL lu_drop: got %0b want 0", loaduse_o); end
    tick();
    checks++; if ({valid_o, pc_o, rd_o} !== {1'b1, 32'h200, 5'd6}) begin failures++; $display("FAIL lu_recap: got v=%0b pc=%h rd=%0d want v=1 pc=200 rd=6", valid_o, pc_o, rd_o); end
    checks++; if (rs2data_o !== 32'hCAFE) begin failures++; $display("FAIL lu_recap_byp: got %h want cafe", rs2data_o); end
  endtask

  task automatic test_stall_wb();
    drive_idle();
    valid_i = 1; memread_i = 1; regwren_i = 1; rd_i = 4; rs1_i = 2; rs2_i = 9;
    rs2data_i = 32'h5555; pc_i = 32'h300;
    tick();
    drive_idle();
    stall_i = 1; valid_i = 1; rs1_i = 4; pc_i = 32'h304; rd_i = 10;
    wb_regwren_i = 1; wb_rd_i = 9; wb_data_i = 32'hBEEF;
    #1;
    checks++; if (loaduse_o !== 1'b1) begin failures++; $display("FAIL st_lu_visible: got %0b want 1", loaduse_o); end
    tick();
    checks++; if ({valid_o, memread_o, pc_o, rd_o} !== {2'b11, 32'h300, 5'd4}) begin failures++; $display("FAIL st_hold1: got v=%0b m=%0b pc=%h rd=%0d want 1 1 300 4", valid_o, memread_o, pc_o, rd_o); end
    checks++; if (rs2data_o !== 32'hBEEF) begin failures++; $display("FAIL st_wb: got %h want beef", rs2data_o); end
    checks++; if (bubble_cnt_o !== m_cnt) begin failures++; $display("FAIL st_nocount: got %0d want %0d", bubble_cnt_o, m_cnt); end
    wb_regwren_i = 0;
    tick();
    checks++; if ({pc_o, rs2data_o, rs2_o} !== {32'h300, 32'hBEEF, 5'd9}) begin failures++; $display("FAIL st_hold2: got pc=%h d=%h rs2=%0d want 300 beef 9", pc_o, rs2data_o, rs2_o); end
    stall_i = 0;
    tick();
    checks++; if ({valid_o, bubble_cnt_o} !== {1'b0, m_cnt}) begin failures++; $display("FAIL st_release_bubble: got v=%0b cnt=%0d want 0 %0d", valid_o, bubble_cnt_o, m_cnt); end
    tick();
    checks++; if ({valid_o, pc_o} !== {1'b1, 32'h304}) begin failures++; $display("FAIL st_recap: got v=%0b pc=%h want 1 304", valid_o, pc_o); end
  endtask

  task automatic test_flush_stall();
    drive_idle();
    valid_i = 1; regwren_i = 1; pc_i = 32'h400; rd_i = 12;
    tick();
    flush_i = 1; stall_i = 1;
    tick();
    checks++; if ({valid_o, regwren_o, memread_o} !== 3'b000) begin failures++; $display("FAIL fl_kill: got %b want 000", {valid_o, regwren_o, memread_o}); end
    checks++; if (bubble_cnt_o !== m_cnt) begin failures++; $display("FAIL fl_nocount: got %0d want %0d", bubble_cnt_o, m_cnt); end
    drive_idle();
    tick();
  endtask

  task automatic test_async_reset();
    drive_idle();
    valid_i = 1; regwren_i = 1; pc_i = 32'h4F0; rs1data_i = 32'h77;
    tick();
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++; if ({valid_o, regwren_o, bubble_cnt_o} !== 18'h0) begin failures++; $display("FAIL ar_ctl: got v=%0b w=%0b cnt=%0d want 0 0 0", valid_o, regwren_o, bubble_cnt_o); end
    checks++; if ({pc_o, rs1data_o} !== 64'h0) begin failures++; $display("FAIL ar_data: got pc=%h d=%h want 0 0", pc_o, rs1data_o); end
    @(negedge clk);
    pc_i = 32'h500;
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ar_held: got %0b want 0", valid_o); end
    rst = 1;
    tick();
    checks++; if ({valid_o, pc_o} !== {1'b1, 32'h500}) begin failures++; $display("FAIL ar_first_cap: got v=%0b pc=%h want 1 500", valid_o, pc_o); end
  endtask

  task automatic test_saturation();
    drive_idle();
    tick();
    force dut.bubble_cnt = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.bubble_cnt;
    m_cnt = 16'hFFFD;
    m_valid = 0; m_regwren = 0; m_memread = 0;
    // A self-dependent load alternates capture and bubble every cycle.
    valid_i = 1; memread_i = 1; regwren_i = 1; rd_i = 3; rs1_i = 3; rs2_i = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bubble_cnt_o !== m_cnt) begin failures++; $display("FAIL sat_step%0d: got %h want %h", i, bubble_cnt_o, m_cnt); end
    end
    checks++; if (bubble_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_final: got %h want ffff", bubble_cnt_o); end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      stall_i      = ($urandom_range(0, 5) == 0);
      flush_i      = ($urandom_range(0, 9) == 0);
      pc_i         = $urandom;
      imm_i        = $urandom;
      rs1_i        = 5'($urandom_range(0, 7));
      rs2_i        = 5'($urandom_range(0, 7));
      rd_i         = 5'($urandom_range(0, 7));
      rs1data_i    = $urandom;
      rs2data_i    = $urandom;
      regwren_i    = 1'($urandom_range(0, 1));
      memread_i    = ($urandom_range(0, 2) == 0);
      ctrl_i       = 8'($urandom);
      wb_rd_i      = 5'($urandom_range(0, 7));
      wb_data_i    = $urandom;
      wb_regwren_i = 1'($urandom_range(0, 1));
      #1;
      checks++; if (loaduse_o !== model_lu()) begin failures++; $display("FAIL rnd_lu[%0d]: got %0b want %0b", n, loaduse_o, model_lu()); end
      tick();
      checks++; if ({valid_o, regwren_o, memread_o} !== {m_valid, m_regwren, m_memread}) begin failures++; $display("FAIL rnd_ctl[%0d]: got %b want %b", n, {valid_o, regwren_o, memread_o}, {m_valid, m_regwren, m_memread}); end
      checks++; if (bubble_cnt_o !== m_cnt) begin failures++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, bubble_cnt_o, m_cnt); end
      if (m_valid) begin
        checks++; if ({pc_o, imm_o, ctrl_o} !== {m_pc, m_imm, m_ctrl}) begin failures++; $display("FAIL rnd_fields[%0d]: got %h %h %h want %h %h %h", n, pc_o, imm_o, ctrl_o, m_pc, m_imm, m_ctrl); end
        checks++; if ({rs1_o, rs2_o, rd_o} !== {m_rs1, m_rs2, m_rd}) begin failures++; $display("FAIL rnd_regs[%0d]: got %0d %0d %0d want %0d %0d %0d", n, rs1_o, rs2_o, rd_o, m_rs1, m_rs2, m_rd); end
        checks++; if ({rs1data_o, rs2data_o} !== {m_rs1data, m_rs2data}) begin failures++; $display("FAIL rnd_ops[%0d]: got %h %h want %h %h", n, rs1data_o, rs2data_o, m_rs1data, m_rs2data); end
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_loaduse();
    test_stall_wb();
    test_flush_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
